replay_sched: RTL

//  Replay scheduler for the linear replay pipeline. Collects replay requests from R

---
 rtl/replay_sched_if.sv | 31 +++
 rtl/replay_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/replay_sched_if.sv
// rtl/replay_sched_if.sv - replay request/issue bundle between requesters and the scheduler
// Signals:
//   req_vld    requester -> scheduler  one replay request per source
//   req_stg    requester -> scheduler  target stage per source, packed [R-1:0][SW-1:0]
//   req_rdy    scheduler -> requester  source may present a request
//   replay_vld scheduler -> pipeline   replay issued this cycle
//   replay_stg scheduler -> pipeline   stage being replayed
//   kill       scheduler -> pipeline   kill mask, bits [replay_stg:0]
// Modports: master = requester/pipeline side, slave = scheduler side.
interface replay_sched_if #(
    parameter int N  = 10,
    parameter int R  = 4,
    parameter int SW = 4
);
    logic [R-1:0]         req_vld;
    logic [R-1:0][SW-1:0] req_stg;
    logic [R-1:0]         req_rdy;
    logic                 replay_vld;
    logic [SW-1:0]        replay_stg;
    logic [N-1:0]         kill;

    modport master (
        output req_vld, req_stg,
        input  req_rdy, replay_vld, replay_stg, kill
    );

    modport slave (
        input  req_vld, req_stg,
        output req_rdy, replay_vld, replay_stg, kill
    );
endinterface

// File: rtl/replay_sched.sv
// rtl/replay_sched.sv - replay scheduler with oldest-first pick, kill mask and livelock backoff
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     request capture (req_vld/req_stg/req_rdy) and replay issue
//                   (replay_vld/replay_stg/kill), see replay_sched_if
//   stg_vld         pipeline valid vector, stages N-1..1
//   commit          commit-stage advance pulse, clears the livelock counter
//   backoff_stall   registered front-end stall during a backoff window
//   pend            registered pending vector
//   err             sticky flag: a request named an illegal stage
//   stat_replays    replays issued (counter only with REPLAY_SCHED_STATS_EN)
//   stat_backoffs   backoff windows entered (counter only with REPLAY_SCHED_STATS_EN)
// Optional feature macro: REPLAY_SCHED_STATS_EN (statistics counters; tied to 0 when undefined).
module replay_sched #(
    parameter int N       = 10,
    parameter int R       = 4,
    parameter int SW      = 4,
    parameter int THRESH  = 3,
    parameter int BACKOFF = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    replay_sched_if.slave bus,
    input  logic [N-1:1]  stg_vld,
    input  logic          commit,
    output logic          backoff_stall,
    output logic [R-1:0]  pend,
    output logic          err,
    output logic [15:0]   stat_replays,
    output logic [15:0]   stat_backoffs
);

    typedef enum logic {IDLE, BACKOFF_ST} state_t;

    state_t               state;
    logic [R-1:0]         pend_r;
    logic [R-1:0][SW-1:0] stg_r;
    logic [3:0]           cnt_r;
    logic [7:0]           bo_r;

    // Stage 0 is never a legal replay target, so its valid bit is pinned low.
    logic [N-1:0]  vld_full;
    logic [R-1:0]  elig;
    logic [R-1:0]  legal;
    logic [R-1:0]  clr;
    logic          any_elig;
    logic [SW-1:0] win_stg;
    logic [N-1:0]  kill_c;
    logic          bo_enter;
    logic          bo_exit;

    assign vld_full = {stg_vld, 1'b0};

    always_comb begin
        elig     = '0;
        legal    = '0;
        clr      = '0;
        any_elig = 1'b0;
        win_stg  = '0;
        kill_c   = '0;
        for (int i = 0; i < R; i++) begin
            elig[i]  = pend_r[i] & vld_full[stg_r[i]];
            legal[i] = (bus.req_stg[i] != '0) && (int'(bus.req_stg[i]) < N);
        end
        // Strictly-greater update keeps the lowest source index on a tie.
        for (int i = 0; i < R; i++) begin
            if (elig[i] && (!any_elig || (stg_r[i] > win_stg))) begin
                any_elig = 1'b1;
                win_stg  = stg_r[i];
            end
        end
        for (int k = 0; k < N; k++) begin
            kill_c[k] = any_elig & (int'(win_stg) >= k);
        end
        // Everything at or behind the replayed stage is killed, so its pending entry goes too.
        for (int j = 0; j < R; j++) begin
            clr[j] = any_elig & (stg_r[j] <= win_stg);
        end
    end

    assign bus.replay_vld = any_elig;
    assign bus.replay_stg = win_stg;
    assign bus.kill       = kill_c;
    assign bus.req_rdy    = ~pend_r;
    assign pend           = pend_r;

    assign bo_enter = (state == IDLE) && any_elig && !commit && (cnt_r == 4'(THRESH - 1));
    assign bo_exit  = (state == BACKOFF_ST) && (bo_r == 8'd1);

    // Request capture and clear. A source whose entry clears this cycle still sees
    // req_rdy low, so a same-cycle request is not taken and must be re-presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
            stg_r  <= '0;
            err    <= 1'b0;
        end else begin
            for (int i = 0; i < R; i++) begin
                if (pend_r[i]) begin
                    if (clr[i]) begin
                        pend_r[i] <= 1'b0;
                    end
                end else if (bus.req_vld[i] && legal[i]) begin
                    pend_r[i] <= 1'b1;
                    stg_r[i]  <= bus.req_stg[i];
                end
            end
            if (|(bus.req_vld & ~pend_r & ~legal)) begin
                err <= 1'b1;
            end
        end
    end

    // Livelock counter and backoff FSM. Commit and window exit both zero the counter
    // and take precedence over a same-cycle replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt_r         <= '0;
            bo_r          <= '0;
            backoff_stall <= 1'b0;
        end else begin
            if (commit || bo_exit) begin
                cnt_r <= '0;
            end else if (any_elig && (cnt_r != 4'hF)) begin
                cnt_r <= cnt_r + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (bo_enter) begin
                        state         <= BACKOFF_ST;
                        bo_r          <= 8'(BACKOFF);
                        backoff_stall <= 1'b1;
                    end
                end
                BACKOFF_ST: begin
                    // Replays inside the window do not restart it.
                    if (bo_r == 8'd1) begin
                        state         <= IDLE;
                        backoff_stall <= 1'b0;
                    end else begin
                        bo_r <= bo_r - 8'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    backoff_stall <= 1'b0;
                end
            endcase
        end
    end

`ifdef REPLAY_SCHED_STATS_EN
    logic [15:0] rep_cnt;
    logic [15:0] bo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            bo_cnt  <= '0;
        end else begin
            if (any_elig && (rep_cnt != 16'hFFFF)) begin
                rep_cnt <= rep_cnt + 16'd1;
            end
            if (bo_enter && (bo_cnt != 16'hFFFF)) begin
                bo_cnt <= bo_cnt + 16'd1;
            end
        end
    end

    assign stat_replays  = rep_cnt;
    assign stat_backoffs = bo_cnt;
`else
    assign stat_replays  = '0;
    assign stat_backoffs = '0;
`endif

endmodule
